// File: rtl/trig_capture_pkg.sv
// Shared definitions for the scope trigger and capture stages.
package trig_capture_pkg;

    // Default sample width shared with the trigger stage.
    localparam int unsigned DWL_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

endpackage

// File: rtl/trig_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module trig_capture_ram #(
    parameter int unsigned DWL = 8,
    parameter int unsigned AWL = 10
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           we_i,
    input  logic [AWL-1:0] waddr_i,
    input  logic [DWL-1:0] wdata_i,
    input  logic           re_i,
    input  logic [AWL-1:0] raddr_i,
    output logic [DWL-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << AWL;

    logic [DWL-1:0] mem_q [DEPTH];
    logic [DWL-1:0] rdata_q;

    // Sample array write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; only the output register is cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trig_capture.sv
// Pre/post-trigger capture into a ring buffer, then oldest-first readout.
module trig_capture
    import trig_capture_pkg::*;
#(
    parameter int unsigned DWL = DWL_DEFAULT,
    parameter int unsigned AWL = 10
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic [DWL-1:0] I_DIN,
    input  logic           I_DEN,
    input  logic           I_TRIG_ON,
    input  logic           I_ARM,
    input  logic [AWL-1:0] I_PRE_LEN,
    input  logic           I_RD_EN,
    output logic [DWL-1:0] O_RD_DATA,
    output logic           O_RD_VALID,
    output logic           O_RD_LAST,
    output logic           O_BUSY,
    output logic           O_DONE,
    output logic [AWL-1:0] O_TRIG_ADDR
);

    localparam int unsigned   N         = 32'd1 << AWL;
    localparam logic [AWL-1:0] LAST_ADDR = AWL'(N - 1);
    localparam logic [AWL:0]   RD_TOTAL  = (AWL + 1)'(N);
    localparam logic [AWL:0]   RD_FINAL  = (AWL + 1)'(N - 1);

    cap_state_e     state_q, state_d;
    logic [AWL-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWL-1:0] cnt_q, cnt_d;
    logic [AWL-1:0] pre_len_q, pre_len_d;
    logic [AWL-1:0] post_rem_q, post_rem_d;
    logic [AWL-1:0] trig_addr_q, trig_addr_d;
    logic [AWL:0]   rd_cnt_q, rd_cnt_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_last_q, rd_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ram_we, ram_re;
    logic [AWL-1:0] ram_raddr;

    // State register plus all pointers, counters and registered outputs.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_len_q   <= '0;
            post_rem_q  <= '0;
            trig_addr_q <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_len_q   <= pre_len_d;
            post_rem_q  <= post_rem_d;
            trig_addr_q <= trig_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, write/read control; I_ARM overrides everything.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_len_d   = pre_len_q;
        post_rem_d  = post_rem_q;
        trig_addr_d = trig_addr_q;
        rd_cnt_d    = rd_cnt_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_raddr   = '0;

        if (I_ARM) begin
            pre_len_d = I_PRE_LEN;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            rd_cnt_d  = '0;
            state_d   = (I_PRE_LEN == '0) ? ST_WAIT_TRIG : ST_PREFILL;
        end else begin
            unique case (state_q)
                ST_PREFILL: begin
                    if (I_DEN) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AWL'(1);
                        cnt_d    = cnt_q + AWL'(1);
                        if (cnt_d == pre_len_q) begin
                            state_d = ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (I_DEN) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AWL'(1);
                        if (I_TRIG_ON) begin
                            trig_addr_d = wr_ptr_q;
                            post_rem_d  = LAST_ADDR - pre_len_q;
                            state_d     = (pre_len_q == LAST_ADDR) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (I_DEN) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AWL'(1);
                        post_rem_d = post_rem_q - AWL'(1);
                        if (post_rem_q == AWL'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Window starts pre_len samples before the trigger address.
                    if (I_RD_EN && (rd_cnt_q < RD_TOTAL)) begin
                        ram_re     = 1'b1;
                        ram_raddr  = trig_addr_q - pre_len_q + rd_cnt_q[AWL-1:0];
                        rd_cnt_d   = rd_cnt_q + (AWL + 1)'(1);
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_cnt_q == RD_FINAL);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == ST_PREFILL) || (state_d == ST_WAIT_TRIG) || (state_d == ST_POST);
        done_d = (state_d == ST_DONE);
    end

    trig_capture_ram #(
        .DWL (DWL),
        .AWL (AWL)
    ) u_ram (
        .clk_i   (I_CLK),
        .rst_ni  (I_RST_N),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (I_DIN),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (O_RD_DATA)
    );

    assign O_RD_VALID  = rd_valid_q;
    assign O_RD_LAST   = rd_last_q;
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_TRIG_ADDR = trig_addr_q;

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture with N=16 ring and ramp sample data.
module tb_trig_capture;

    localparam int unsigned DWL = 8;
    localparam int unsigned AWL = 4;

    logic           I_CLK = 1'b0;
    logic           I_RST_N;
    logic [DWL-1:0] I_DIN;
    logic           I_DEN;
    logic           I_TRIG_ON;
    logic           I_ARM;
    logic [AWL-1:0] I_PRE_LEN;
    logic           I_RD_EN;
    logic [DWL-1:0] O_RD_DATA;
    logic           O_RD_VALID;
    logic           O_RD_LAST;
    logic           O_BUSY;
    logic           O_DONE;
    logic [AWL-1:0] O_TRIG_ADDR;

    int checks   = 0;
    int failures = 0;

    trig_capture #(.DWL(DWL), .AWL(AWL)) dut (
        .I_CLK       (I_CLK),
        .I_RST_N     (I_RST_N),
        .I_DIN       (I_DIN),
        .I_DEN       (I_DEN),
        .I_TRIG_ON   (I_TRIG_ON),
        .I_ARM       (I_ARM),
        .I_PRE_LEN   (I_PRE_LEN),
        .I_RD_EN     (I_RD_EN),
        .O_RD_DATA   (O_RD_DATA),
        .O_RD_VALID  (O_RD_VALID),
        .O_RD_LAST   (O_RD_LAST),
        .O_BUSY      (O_BUSY),
        .O_DONE      (O_DONE),
        .O_TRIG_ADDR (O_TRIG_ADDR)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    // Arm, then feed ramp samples until O_DONE; returns last ramp value written.
    task automatic run_capture(input int pre, input int trig_at, input bit free_trig,
                               input bit alt, output int last_k);
        int k;
        I_ARM     = 1'b1;
        I_PRE_LEN = AWL'(pre);
        I_DEN     = 1'b1;
        I_DIN     = 8'hAA;
        I_TRIG_ON = 1'b1;
        step();
        I_ARM = 1'b0;
        chk("busy_after_arm", 32'(O_BUSY), 32'd1);
        chk("done_after_arm", 32'(O_DONE), 32'd0);
        k = 0;
        for (int cyc = 0; cyc < 200 && !O_DONE; cyc++) begin
            if (!alt || (cyc % 2 == 0)) begin
                I_DEN     = 1'b1;
                I_DIN     = 8'(k);
                I_TRIG_ON = free_trig || (k == trig_at);
                k++;
            end else begin
                I_DEN     = 1'b0;
                I_DIN     = 8'hEE;
                I_TRIG_ON = 1'b1;
            end
            step();
        end
        I_DEN     = 1'b0;
        I_TRIG_ON = 1'b0;
        last_k    = k - 1;
        chk("done_reached", 32'(O_DONE), 32'd1);
        chk("busy_cleared", 32'(O_BUSY), 32'd0);
    endtask

    // Back-to-back reads of the whole window plus one surplus request.
    task automatic read_window(input int first);
        I_RD_EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("rd_valid", 32'(O_RD_VALID), 32'd1);
            chk("rd_data", 32'(O_RD_DATA), 32'(8'(first + i)));
            chk("rd_last", 32'(O_RD_LAST), (i == 15) ? 32'd1 : 32'd0);
        end
        step();
        chk("rd_17th_valid", 32'(O_RD_VALID), 32'd0);
        chk("rd_17th_last", 32'(O_RD_LAST), 32'd0);
        I_RD_EN = 1'b0;
        step();
        chk("done_held", 32'(O_DONE), 32'd1);
    endtask

    initial begin
        int last_k;
        I_RST_N   = 1'b1;
        I_DIN     = '0;
        I_DEN     = 1'b0;
        I_TRIG_ON = 1'b0;
        I_ARM     = 1'b0;
        I_PRE_LEN = '0;
        I_RD_EN   = 1'b0;
        #2 I_RST_N = 1'b0;
        #1;
        chk("rst_busy", 32'(O_BUSY), 32'd0);
        chk("rst_done", 32'(O_DONE), 32'd0);
        chk("rst_valid", 32'(O_RD_VALID), 32'd0);
        chk("rst_last", 32'(O_RD_LAST), 32'd0);
        chk("rst_data", 32'(O_RD_DATA), 32'd0);
        chk("rst_trig_addr", 32'(O_TRIG_ADDR), 32'd0);
        step();
        I_RST_N = 1'b1;
        step();
        I_RD_EN = 1'b1;
        step();
        chk("idle_rd_ignored", 32'(O_RD_VALID), 32'd0);
        I_RD_EN = 1'b0;

        // 1: continuous valid, pre_len=4, trigger at 20
        run_capture(4, 20, 1'b0, 1'b0, last_k);
        chk("s1_trig_addr", 32'(O_TRIG_ADDR), 32'd4);
        chk("s1_last_written", 32'(last_k), 32'd31);
        read_window(16);

        // 2: free-running trigger, PREFILL ignores it
        run_capture(4, 0, 1'b1, 1'b0, last_k);
        chk("s2_trig_addr", 32'(O_TRIG_ADDR), 32'd4);
        chk("s2_last_written", 32'(last_k), 32'd15);
        read_window(0);

        // 3: pre_len=0 skips PREFILL
        run_capture(0, 7, 1'b0, 1'b0, last_k);
        chk("s3_trig_addr", 32'(O_TRIG_ADDR), 32'd7);
        chk("s3_last_written", 32'(last_k), 32'd22);
        read_window(7);

        // 4: pre_len=15, DONE directly after the trigger write
        run_capture(15, 30, 1'b0, 1'b0, last_k);
        chk("s4_trig_addr", 32'(O_TRIG_ADDR), 32'd14);
        chk("s4_last_written", 32'(last_k), 32'd30);
        read_window(15);

        // 5: alternating valid with triggers on invalid cycles
        run_capture(4, 20, 1'b0, 1'b1, last_k);
        chk("s5_trig_addr", 32'(O_TRIG_ADDR), 32'd4);
        chk("s5_last_written", 32'(last_k), 32'd31);
        read_window(16);

        // 6a: reset in the middle of POST
        I_ARM     = 1'b1;
        I_PRE_LEN = AWL'(4);
        step();
        I_ARM = 1'b0;
        I_DEN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            I_DIN     = 8'(k);
            I_TRIG_ON = (k == 5);
            step();
        end
        I_DEN     = 1'b0;
        I_TRIG_ON = 1'b0;
        chk("s6_busy_post", 32'(O_BUSY), 32'd1);
        chk("s6_trig_addr_post", 32'(O_TRIG_ADDR), 32'd5);
        I_RST_N = 1'b0;
        #1;
        chk("s6_rst_busy", 32'(O_BUSY), 32'd0);
        chk("s6_rst_done", 32'(O_DONE), 32'd0);
        chk("s6_rst_trig_addr", 32'(O_TRIG_ADDR), 32'd0);
        chk("s6_rst_data", 32'(O_RD_DATA), 32'd0);
        chk("s6_rst_valid", 32'(O_RD_VALID), 32'd0);
        step();
        I_RST_N = 1'b1;
        I_RD_EN = 1'b1;
        step();
        step();
        chk("s6_rd_after_rst", 32'(O_RD_VALID), 32'd0);
        chk("s6_done_after_rst", 32'(O_DONE), 32'd0);
        I_RD_EN = 1'b0;

        // 6b: re-arm during WAIT_TRIG restarts the capture
        I_ARM     = 1'b1;
        I_PRE_LEN = AWL'(4);
        step();
        I_ARM = 1'b0;
        I_DEN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            I_DIN = 8'(100 + k);
            step();
        end
        I_DEN = 1'b0;
        chk("s6b_busy_wait", 32'(O_BUSY), 32'd1);
        run_capture(4, 20, 1'b0, 1'b0, last_k);
        chk("s6b_trig_addr", 32'(O_TRIG_ADDR), 32'd4);
        chk("s6b_last_written", 32'(last_k), 32'd31);
        read_window(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Capture buffer that consumes the sample stream, valid and trigger flag produced by the trigger stage (O_DOUT / O_DOV / O_TRIG_ON) in the scope datapath.
- Once armed, it records a programmable number of pre-trigger samples and then waits for a trigger.
- It fills the remainder of a 2^AWL-entry ring buffer with post-trigger samples, then plays the whole window out, oldest sample first, to the display/host reader.

Parameters:
DWL, 8, sample width in bits (matches trigger stage)
AWL, 10, buffer address width; depth N = 2^AWL samples

Ports:
I_CLK  input  1  clock, posedge active
I_RST_N  input  1  asynchronous active-low reset
I_DIN  input  DWL  sample from trigger stage O_DOUT
I_DEN  input  1  sample valid, from trigger stage O_DOV
I_TRIG_ON  input  1  trigger flag, from trigger stage O_TRIG_ON, aligned with I_DIN
I_ARM  input  1  one-cycle pulse: start a new capture
I_PRE_LEN  input  AWL  pre-trigger sample count, sampled on I_ARM
I_RD_EN  input  1  readout request, one sample per asserted cycle
O_RD_DATA  output  DWL  readout sample
O_RD_VALID  output  1  O_RD_DATA valid
O_RD_LAST  output  1  marks the N-th (final) readout sample, with O_RD_VALID
O_BUSY  output  1  capture in progress (PREFILL/WAIT_TRIG/POST)
O_DONE  output  1  window complete and readable
O_TRIG_ADDR  output  AWL  buffer address holding the trigger sample

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is asynchronous, active-low (I_RST_N).
- Reset values: state IDLE; all pointers and counters 0; O_RD_DATA, O_RD_VALID, O_RD_LAST, O_BUSY, O_DONE and O_TRIG_ADDR all 0. Buffer contents are undefined and are not cleared.
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- Writes: a sample is written to mem[wr_ptr] only when I_DEN=1 in PREFILL, WAIT_TRIG or POST. wr_ptr then increments modulo N.
- I_ARM (any state, highest priority):
  - latch pre_len = I_PRE_LEN; wr_ptr = 0; cnt = 0; rd counters cleared;
  - next state is PREFILL, or WAIT_TRIG if I_PRE_LEN = 0;
  - the sample present in the I_ARM cycle is not written.
- PREFILL:
  - each written sample increments cnt;
  - when the write makes cnt = pre_len, go to WAIT_TRIG;
  - I_TRIG_ON is ignored in this state.
- WAIT_TRIG:
  - samples are written continuously (the ring wraps freely);
  - I_TRIG_ON counts only together with I_DEN=1. When both are 1, that sample is written, O_TRIG_ADDR = wr_ptr, and post_rem = N-1-pre_len;
  - if post_rem = 0 go to DONE, else go to POST.
- POST: each written sample decrements post_rem. The write that takes post_rem to 0 moves to DONE in the same edge.
- O_BUSY = 1 exactly in PREFILL, WAIT_TRIG and POST. O_DONE = 1 exactly in DONE (registered; they change together with the state).
- Window: exactly N samples. start = O_TRIG_ADDR - pre_len (mod N); the trigger sample is the (pre_len+1)-th sample read.
- Readout, DONE state only:
  - I_RD_EN reads mem[start + rd_cnt] and increments rd_cnt;
  - synchronous RAM read: O_RD_DATA and O_RD_VALID are asserted 1 cycle after the accepted I_RD_EN;
  - O_RD_LAST accompanies the read with rd_cnt = N-1;
  - after N reads, I_RD_EN is ignored and O_RD_VALID stays 0 until the next I_ARM;
  - O_DONE remains 1 until I_ARM.
- Ignored inputs: I_RD_EN outside DONE, and I_RD_EN in the same cycle as I_ARM. O_RD_VALID/O_RD_LAST are 0 in every cycle not following an accepted read.
- Reset mid-operation: immediate return to the reset state; a partial capture is discarded.

Decomposition:
- Shared package: state encoding constants (IDLE/PREFILL/WAIT_TRIG/POST/DONE) and the DWL default used by both the trigger stage and the capture stage.
- One sub-module: trig_capture_ram, a simple dual-port RAM (one write port, one registered read port), DWL x 2^AWL, with no reset on the array.
- The FSM, pointers and counters stay in trig_capture.

Test Plan:
All scenarios use DWL=8, AWL=4 (N=16), with ramp data din=0,1,2,... starting the cycle after I_ARM.
1. I_DEN=1 continuous, pre_len=4, I_TRIG_ON=1 only at din=20 -> O_TRIG_ADDR=4. 16 reads return 16..31; O_RD_LAST on 31; the 17th I_RD_EN gives no O_RD_VALID.
2. Free mode: I_TRIG_ON held 1, pre_len=4 -> trigger taken at din=4 (PREFILL ignores the trigger); readout returns 0..15.
3. pre_len=0, trigger at din=7 -> PREFILL is skipped; readout returns 7..22; the first read equals the trigger sample.
4. pre_len=15, trigger at din=30 -> DONE the edge after the trigger write with no POST cycles; readout returns 15..30.
5. Scenario 1 with I_DEN alternating 1/0 and I_TRIG_ON=1 during an I_DEN=0 cycle -> that trigger is ignored; stored/readout values are identical to scenario 1.
6. Assert I_RST_N=0 mid-POST -> all outputs 0 immediately and I_RD_EN is ignored. Then, separately, pulse I_ARM during WAIT_TRIG -> the capture restarts, and a subsequent trigger yields a correct window.
